id_ex_stage: RTL and testbench

- ID/EX pipeline stage that sits directly downstream of the register file.
- Captures the register file read data, immediate, register addresses and decoded control into the EX-side pipeline register.
- Adds a write-back bypass to cover the register file's same-cycle write/read gap.
- Detects load-use hazards, inserts bubbles, honours branch flushes, and keeps a saturating stall counter.

---
 rtl/id_ex_stage.sv | 176 +++++++++++++++++
 tb/tb_id_ex_stage.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//   ID/EX pipeline register placed directly after the register file.
//   - Forwards the write-back value into the operands when the register file
//     has not yet absorbed a same-cycle write (register 0 is never forwarded).
//   - Detects load-use hazards against the instruction currently in EX and
//     inserts a single bubble while asking upstream to hold (stall).
//   - Branch flush kills the ID instruction and overrides the stall request.
//   - Counts stall cycles in a saturating counter with synchronous clear.
//
// Ports
//   clk, rst            : rising-edge clock, asynchronous active-high reset
//   rs, rt, rd, usesRt  : ID register fields and "reads rt" flag
//   readData1/2, imm    : register file read data and sign-extended immediate
//   idValid, ctrlIn     : ID valid and decoded control
//                         {regWrite, memRead, memWrite, memToReg,
//                          aluSrc, regDst, aluOp[1:0]}
//   wbRegWrite/Adr/Data : write-back port (also feeding the register file)
//   flush               : branch taken, kill ID instruction
//   cntClr              : synchronous stall counter clear
//   stall               : combinational hold request for PC and IF/ID
//   ex*                 : registered EX-side pipeline fields
//   stallCount          : saturating number of stall cycles
// -----------------------------------------------------------------------------
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  input  logic [ADDR_W-1:0] rd,
  input  logic              usesRt,
  input  logic [DATA_W-1:0] readData1,
  input  logic [DATA_W-1:0] readData2,
  input  logic [DATA_W-1:0] imm,
  input  logic              idValid,
  input  logic [7:0]        ctrlIn,
  input  logic              wbRegWrite,
  input  logic [ADDR_W-1:0] wbWriteAdr,
  input  logic [DATA_W-1:0] wbWriteData,
  input  logic              flush,
  input  logic              cntClr,
  output logic              stall,
  output logic              exValid,
  output logic [7:0]        exCtrl,
  output logic [DATA_W-1:0] exA,
  output logic [DATA_W-1:0] exB,
  output logic [DATA_W-1:0] exImm,
  output logic [ADDR_W-1:0] exRs,
  output logic [ADDR_W-1:0] exRt,
  output logic [ADDR_W-1:0] exDest,
  output logic [CNT_W-1:0]  stallCount
);

  // Control bit positions inside ctrlIn / exCtrl
  localparam int CTRL_MEM_READ = 6;
  localparam int CTRL_REG_DST  = 2;

  localparam logic [ADDR_W-1:0] ZERO_ADR = {ADDR_W{1'b0}};
  localparam logic [DATA_W-1:0] ZERO_DAT = {DATA_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0] op_a_s;
  logic [DATA_W-1:0] op_b_s;
  logic              hazard_s;

  logic              ex_valid_d, ex_valid_q;
  logic [7:0]        ex_ctrl_d,  ex_ctrl_q;
  logic [DATA_W-1:0] ex_a_d,     ex_a_q;
  logic [DATA_W-1:0] ex_b_d,     ex_b_q;
  logic [DATA_W-1:0] ex_imm_d,   ex_imm_q;
  logic [ADDR_W-1:0] ex_rs_d,    ex_rs_q;
  logic [ADDR_W-1:0] ex_rt_d,    ex_rt_q;
  logic [ADDR_W-1:0] ex_dest_d,  ex_dest_q;
  logic [CNT_W-1:0]  cnt_d,      cnt_q;

  // Write-back bypass: covers the register file's same-cycle write/read gap
  always_comb begin
    if (wbRegWrite && (wbWriteAdr == rs) && (rs != ZERO_ADR)) begin
      op_a_s = wbWriteData;
    end else begin
      op_a_s = readData1;
    end
    if (wbRegWrite && (wbWriteAdr == rt) && (rt != ZERO_ADR)) begin
      op_b_s = wbWriteData;
    end else begin
      op_b_s = readData2;
    end
  end

  // Load in EX whose destination feeds the ID instruction. Depends on
  // exValid_q, so an asynchronous reset drops it immediately.
  assign hazard_s = ex_valid_q && ex_ctrl_q[CTRL_MEM_READ] &&
                    (ex_dest_q != ZERO_ADR) && idValid &&
                    ((ex_dest_q == rs) || (usesRt && (ex_dest_q == rt)));

  // A taken branch kills the ID instruction, so holding it would be pointless
  assign stall = hazard_s && !flush;

  // Next pipeline register contents: bubble on flush or stall, else load
  always_comb begin
    ex_valid_d = 1'b0;
    ex_ctrl_d  = 8'h00;
    ex_a_d     = ZERO_DAT;
    ex_b_d     = ZERO_DAT;
    ex_imm_d   = ZERO_DAT;
    ex_rs_d    = ZERO_ADR;
    ex_rt_d    = ZERO_ADR;
    ex_dest_d  = ZERO_ADR;
    if (flush || stall) begin
      ex_valid_d = 1'b0;
      ex_ctrl_d  = 8'h00;
    end else begin
      ex_valid_d = idValid;
      // An empty slot must not carry live control (e.g. a stray memRead)
      ex_ctrl_d  = idValid ? ctrlIn : 8'h00;
      ex_a_d     = op_a_s;
      ex_b_d     = op_b_s;
      ex_imm_d   = imm;
      ex_rs_d    = rs;
      ex_rt_d    = rt;
      ex_dest_d  = ctrlIn[CTRL_REG_DST] ? rd : rt;
    end
  end

  // Saturating stall counter, clear has priority over increment
  always_comb begin
    if (cntClr) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (stall && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Pipeline and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      ex_ctrl_q  <= 8'h00;
      ex_a_q     <= ZERO_DAT;
      ex_b_q     <= ZERO_DAT;
      ex_imm_q   <= ZERO_DAT;
      ex_rs_q    <= ZERO_ADR;
      ex_rt_q    <= ZERO_ADR;
      ex_dest_q  <= ZERO_ADR;
      cnt_q      <= {CNT_W{1'b0}};
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_ctrl_q  <= ex_ctrl_d;
      ex_a_q     <= ex_a_d;
      ex_b_q     <= ex_b_d;
      ex_imm_q   <= ex_imm_d;
      ex_rs_q    <= ex_rs_d;
      ex_rt_q    <= ex_rt_d;
      ex_dest_q  <= ex_dest_d;
      cnt_q      <= cnt_d;
    end
  end

  assign exValid    = ex_valid_q;
  assign exCtrl     = ex_ctrl_q;
  assign exA        = ex_a_q;
  assign exB        = ex_b_q;
  assign exImm      = ex_imm_q;
  assign exRs       = ex_rs_q;
  assign exRt       = ex_rt_q;
  assign exDest     = ex_dest_q;
  assign stallCount = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
//   Self-checking bench for id_ex_stage. A behavioural model of the EX-side
//   instruction slot is advanced once per clock and compared against the DUT.
//   The counter width is reduced so saturation is reachable in a short run.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 8;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] rs, rt, rd;
  logic              usesRt;
  logic [DATA_W-1:0] readData1, readData2, imm;
  logic              idValid;
  logic [7:0]        ctrlIn;
  logic              wbRegWrite;
  logic [ADDR_W-1:0] wbWriteAdr;
  logic [DATA_W-1:0] wbWriteData;
  logic              flush, cntClr;
  logic              stall, exValid;
  logic [7:0]        exCtrl;
  logic [DATA_W-1:0] exA, exB, exImm;
  logic [ADDR_W-1:0] exRs, exRt, exDest;
  logic [CNT_W-1:0]  stallCount;

  int checks = 0;
  int errors = 0;

  // Model of the instruction sitting in EX
  bit        m_valid;
  bit [7:0]  m_ctrl;
  bit [31:0] m_a, m_b, m_imm;
  bit [4:0]  m_rs, m_rt, m_dest;
  int        m_cnt;
  bit        last_stall;

  localparam logic [7:0] LW_CTRL = 8'b1100_1000; // regWrite, memRead, aluSrc
  localparam logic [7:0] R_CTRL  = 8'b1000_0110; // regWrite, regDst, aluOp=2

  id_ex_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .rs(rs), .rt(rt), .rd(rd), .usesRt(usesRt),
    .readData1(readData1), .readData2(readData2), .imm(imm),
    .idValid(idValid), .ctrlIn(ctrlIn), .wbRegWrite(wbRegWrite),
    .wbWriteAdr(wbWriteAdr), .wbWriteData(wbWriteData), .flush(flush),
    .cntClr(cntClr), .stall(stall), .exValid(exValid), .exCtrl(exCtrl),
    .exA(exA), .exB(exB), .exImm(exImm), .exRs(exRs), .exRt(exRt),
    .exDest(exDest), .stallCount(stallCount)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_ctrl = 8'h00; m_a = 32'd0; m_b = 32'd0; m_imm = 32'd0;
    m_rs = 5'd0; m_rt = 5'd0; m_dest = 5'd0; m_cnt = 0; last_stall = 1'b0;
  endtask

  // A load in EX stalls any valid ID instruction that reads its destination
  function automatic bit model_stall();
    bit reads_it;
    reads_it = (m_dest == rs) || (usesRt && (m_dest == rt));
    return m_valid && m_ctrl[6] && (m_dest != 5'd0) && idValid && reads_it && !flush;
  endfunction

  // Value an instruction would see for register adr in this cycle
  function automatic bit [31:0] reg_value(input bit [4:0] adr, input bit [31:0] rf);
    if (adr != 5'd0 && wbRegWrite && wbWriteAdr == adr) return wbWriteData;
    return rf;
  endfunction

  task automatic check_all();
    check("exValid", {31'd0, exValid}, {31'd0, m_valid});
    check("exCtrl", {24'd0, exCtrl}, {24'd0, m_ctrl});
    check("exA", exA, m_a);
    check("exB", exB, m_b);
    check("exImm", exImm, m_imm);
    check("exRs", {27'd0, exRs}, {27'd0, m_rs});
    check("exRt", {27'd0, exRt}, {27'd0, m_rt});
    check("exDest", {27'd0, exDest}, {27'd0, m_dest});
    check("stallCount", {24'd0, stallCount}, m_cnt);
  endtask

  // One clock: check stall before the edge, advance model, check after edge
  task automatic step();
    bit st;
    #1;
    st = model_stall();
    check("stall", {31'd0, stall}, {31'd0, st});
    if (cntClr) m_cnt = 0;
    else if (st && m_cnt < CMAX) m_cnt = m_cnt + 1;
    @(posedge clk);
    if (flush || st) begin
      m_valid = 1'b0; m_ctrl = 8'h00; m_a = 32'd0; m_b = 32'd0; m_imm = 32'd0;
      m_rs = 5'd0; m_rt = 5'd0; m_dest = 5'd0;
    end else begin
      m_valid = idValid;
      m_ctrl  = idValid ? ctrlIn : 8'h00;
      m_a     = reg_value(rs, readData1);
      m_b     = reg_value(rt, readData2);
      m_imm   = imm;
      m_rs    = rs;
      m_rt    = rt;
      m_dest  = ctrlIn[2] ? rd : rt;
    end
    last_stall = st;
    #1;
    check_all();
  endtask

  task automatic clear_inputs();
    rs = 5'd0; rt = 5'd0; rd = 5'd0; usesRt = 1'b0;
    readData1 = 32'd0; readData2 = 32'd0; imm = 32'd0;
    idValid = 1'b0; ctrlIn = 8'h00;
    wbRegWrite = 1'b0; wbWriteAdr = 5'd0; wbWriteData = 32'd0;
    flush = 1'b0; cntClr = 1'b0;
  endtask

  task automatic present(input bit [4:0] a_rs, input bit [4:0] a_rt, input bit [4:0] a_rd,
                         input bit a_uses, input bit [7:0] a_ctrl);
    rs = a_rs; rt = a_rt; rd = a_rd; usesRt = a_uses; ctrlIn = a_ctrl; idValid = 1'b1;
    readData1 = $urandom; readData2 = $urandom; imm = $urandom;
  endtask

  task automatic idle();
    clear_inputs();
    step();
  endtask

  initial begin
    model_reset();
    clear_inputs();

    // 1. reset
    rst = 1'b1;
    #100;
    check("rst_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_all();
    check("rst_cnt", {24'd0, stallCount}, 32'd0);

    // 2. bypass
    present(5'd20, 5'd3, 5'd4, 1'b1, R_CTRL);
    readData1 = 32'd0; wbRegWrite = 1'b1; wbWriteAdr = 5'd20; wbWriteData = 32'd9898;
    step();
    check("byp_exA", exA, 32'd9898);
    present(5'd0, 5'd3, 5'd4, 1'b1, R_CTRL);
    readData1 = 32'h1234_5678; wbRegWrite = 1'b1; wbWriteAdr = 5'd0; wbWriteData = 32'd9898;
    step();
    check("byp_r0", exA, 32'h1234_5678);

    // 3. load-use with rs, then rt-only match with usesRt=0
    idle();
    present(5'd3, 5'd21, 5'd0, 1'b0, LW_CTRL);   // lw r21
    step();
    present(5'd21, 5'd4, 5'd6, 1'b1, R_CTRL);
    #1 check("lu_stall", {31'd0, stall}, 32'd1);
    step();
    check("lu_bubble", {24'd0, exCtrl, 7'd0, exValid}, 32'd0);
    step();                                       // same instruction re-presented
    check("lu_load", {31'd0, exValid}, 32'd1);
    check("lu_cnt", {24'd0, stallCount}, 32'd1);
    idle();
    present(5'd3, 5'd21, 5'd0, 1'b0, LW_CTRL);
    step();
    present(5'd5, 5'd21, 5'd6, 1'b0, R_CTRL);
    #1 check("nouse_stall", {31'd0, stall}, 32'd0);
    step();

    // 4. flush during hazard
    idle();
    present(5'd3, 5'd21, 5'd0, 1'b0, LW_CTRL);
    step();
    present(5'd21, 5'd4, 5'd6, 1'b1, R_CTRL);
    flush = 1'b1;
    #1 check("fl_stall", {31'd0, stall}, 32'd0);
    step();
    check("fl_bubble", {31'd0, exValid}, 32'd0);
    check("fl_cnt", {24'd0, stallCount}, 32'd1);
    flush = 1'b0;

    // 5. counter saturation: a self-dependent load stalls every other cycle
    idle();
    present(5'd21, 5'd21, 5'd0, 1'b1, LW_CTRL);
    for (int i = 0; i < 2 * (CMAX + 1) + 8; i++) step();
    check("cnt_sat", {24'd0, stallCount}, CMAX);
    if (!model_stall()) step();
    cntClr = 1'b1;
    #1 check("clr_stall", {31'd0, stall}, 32'd1);
    step();
    check("cnt_clr", {24'd0, stallCount}, 32'd0);
    cntClr = 1'b0;

    // 6. async reset mid-stall
    if (!model_stall()) step();
    #1 check("pre_rst_stall", {31'd0, stall}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_stall", {31'd0, stall}, 32'd0);
    check("arst_valid", {31'd0, exValid}, 32'd0);
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic; ID fields are held while stalled
    clear_inputs();
    for (int i = 0; i < 400; i++) begin
      if (!last_stall) begin
        present($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 1), 8'($urandom));
        if ($urandom_range(0, 1) == 1) ctrlIn[6] = 1'b1;
        idValid = ($urandom_range(0, 7) != 0);
      end
      wbRegWrite  = $urandom_range(0, 1);
      wbWriteAdr  = $urandom_range(0, 3);
      wbWriteData = $urandom;
      flush       = ($urandom_range(0, 7) == 0);
      cntClr      = ($urandom_range(0, 31) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
